req_channel: RTL
================

Name: req_channel

Overview:
- One output channel downstream of the request presenter. Drives that channel's ch0_ready/ch1_ready input, consumes the presented request ID, emits it as a fixed-length AXI-Stream command packet, then waits for a completion pulse before becoming ready again.
- Two instances sit side by side, one per channel. Both see the same req_id/req_id_valid.
- A hung completion is recovered by a timeout that flags an error.

Parameters:
- REQ_ID_WIDTH, 32, width of the request ID.
- PACKET_BEATS, 4, beats per command packet (range 1..65535).
- TIMEOUT_CYCLES, 1000000, cycles allowed in WAIT before abandoning the request (must be >= 1).

Ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- req_id  input  REQ_ID_WIDTH  request ID from the presenter.
- req_id_valid  input  1  request ID is valid and all channels are ready.
- ready  output  1  this channel can accept a request; wired to chN_ready.
- AXIS_TDATA  output  REQ_ID_WIDTH+16  {captured req_id, 16-bit beat index}.
- AXIS_TVALID  output  1  beat valid.
- AXIS_TLAST  output  1  final beat of the packet.
- AXIS_TREADY  input  1  downstream accepts beat.
- done  input  1  single-cycle completion pulse from the downstream consumer.
- timeout_err  output  1  one-cycle pulse when a request times out.
- served_count  output  32  number of requests completed normally; wraps at 2^32.

Behaviour:
- Reset values: state=IDLE, ready=0 during the reset cycle then 1, AXIS_TVALID=0, AXIS_TLAST=0, AXIS_TDATA=0, timeout_err=0, served_count=0, beat index=0, done_seen=0.
- ready is registered. It is 1 only in IDLE, and 0 in every other state and while reset is asserted.
- An accept occurs when req_id_valid=1 and state=IDLE.
  - On accept, req_id is captured and the block moves to SEND.
  - ready drops on the next cycle.
  - The first beat is valid on the cycle after the accept (1-cycle latency).
- req_id_valid while not in IDLE is ignored. The presenter never asserts it then, because ready gates it.
- SEND state:
  - TVALID=1.
  - TDATA={id, idx}, with idx starting at 0.
  - TLAST=1 when idx==PACKET_BEATS-1.
  - TDATA, TLAST and TVALID are held stable while TREADY=0.
  - Each beat handshake (TVALID&TREADY) increments idx.
  - With PACKET_BEATS=1, the single beat carries TLAST=1.
  - On the last-beat handshake, TVALID drops on the next cycle, idx resets to 0, and the block goes to WAIT, or to IDLE if done_seen=1.
- done is honoured in SEND as well as WAIT.
  - A done pulse arriving in SEND, including on the last-beat cycle, sets done_seen.
  - done_seen is cleared on the transition back to IDLE.
- WAIT state:
  - A timeout counter starts at 0 on entry and increments each cycle.
  - done=1 -> go to IDLE and increment served_count.
  - If the counter reaches TIMEOUT_CYCLES-1 with no done -> pulse timeout_err for one cycle, go to IDLE, and leave served_count unchanged.
  - done and timeout in the same cycle: done wins; no error, and the count increments.
- SEND->IDLE via done_seen also increments served_count.
- done in IDLE is ignored.
- Reset mid-packet:
  - The packet is abandoned immediately with no TLAST.
  - TVALID is 0 on the cycle after reset is sampled.
  - All state returns to reset values.
- served_count is modulo-2^32: 0xFFFFFFFF + 1 -> 0.

Test Plan:
- Basic flow: reset, then req_id=0x12345678 valid for 1 cycle, TREADY=1, PACKET_BEATS=4 -> ready drops; beats 0x12345678_0000..0003 on consecutive cycles with TLAST on 0003. A done pulse 5 cycles later -> ready=1, served_count=1.
- Backpressure: TREADY toggling 1,0,0,1,1,0,1 -> exactly 4 beats, none duplicated or skipped, TDATA stable during stalls, TLAST only with idx=3.
- Early done: done pulse on the last-beat handshake cycle -> the block returns straight to IDLE with no WAIT, and served_count increments once.
- Timeout: TIMEOUT_CYCLES=16, no done -> timeout_err pulses exactly 16 cycles after WAIT entry; ready=1 next; served_count unchanged. done coincident with the final timeout cycle -> no error, count+1.
- Reset mid-packet: assert reset after beat 1 handshake -> TVALID=0 next cycle, ready=0 for the reset cycle then 1; a new request 0xABCD0001 starts at idx 0.
- Ignored inputs: req_id_valid held high during SEND/WAIT and done pulsed in IDLE -> no extra packets and no count change; served_count preloaded by 2^32 completions (or forced) wraps to 0.

Source files
------------

// File: rtl/req_channel.sv
// One command channel: accepts a request ID when idle, emits it as a fixed-length
// AXI-Stream packet, then waits for a completion pulse (or a timeout) before re-arming.
module req_channel #(
    parameter int REQ_ID_WIDTH   = 32,
    parameter int PACKET_BEATS   = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REQ_ID_WIDTH-1:0]  req_id,
    input  logic                     req_id_valid,
    output logic                     ready,
    output logic [REQ_ID_WIDTH+15:0] AXIS_TDATA,
    output logic                     AXIS_TVALID,
    output logic                     AXIS_TLAST,
    input  logic                     AXIS_TREADY,
    input  logic                     done,
    output logic                     timeout_err,
    output logic [31:0]              served_count
);

    localparam logic [15:0] LAST_IDX = 16'(PACKET_BEATS - 1);
    localparam logic [31:0] WAIT_MAX = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    ready_q;
    logic [REQ_ID_WIDTH-1:0] id_q;
    logic [15:0]             idx_q;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic                    done_seen_q;
    logic [31:0]             wait_cnt_q;
    logic                    timeout_err_q;
    logic [31:0]             served_q;

    logic        beat_fire;
    logic        last_beat;
    logic [15:0] idx_inc;

    assign beat_fire = tvalid_q && AXIS_TREADY;
    assign last_beat = (idx_q == LAST_IDX);
    assign idx_inc   = idx_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            id_q          <= '0;
            idx_q         <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            done_seen_q   <= 1'b0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            served_q      <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_id_valid) begin
                        id_q        <= req_id;
                        idx_q       <= '0;
                        tvalid_q    <= 1'b1;
                        tlast_q     <= (LAST_IDX == 16'd0);
                        ready_q     <= 1'b0;
                        done_seen_q <= 1'b0;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (done) begin
                        done_seen_q <= 1'b1;
                    end
                    if (beat_fire) begin
                        if (last_beat) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            idx_q    <= '0;
                            // A completion already seen (or arriving now) skips WAIT.
                            if (done_seen_q || done) begin
                                state_q     <= IDLE;
                                ready_q     <= 1'b1;
                                done_seen_q <= 1'b0;
                                served_q    <= served_q + 32'd1;
                            end else begin
                                state_q    <= WAIT;
                                wait_cnt_q <= '0;
                            end
                        end else begin
                            idx_q   <= idx_inc;
                            tlast_q <= (idx_inc == LAST_IDX);
                        end
                    end
                end
                WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 32'd1;
                    // done takes priority over an expiring timeout in the same cycle.
                    if (done) begin
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        done_seen_q <= 1'b0;
                        served_q    <= served_q + 32'd1;
                    end else if (wait_cnt_q == WAIT_MAX) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                        ready_q       <= 1'b1;
                        done_seen_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ready_q  <= 1'b0;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = ready_q;
    assign AXIS_TDATA   = {id_q, idx_q};
    assign AXIS_TVALID  = tvalid_q;
    assign AXIS_TLAST   = tlast_q;
    assign timeout_err  = timeout_err_q;
    assign served_count = served_q;

endmodule
